// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared types and constants for the instruction memory loader
package mips_pkg;

    localparam int          IMEM_ADDR_WIDTH = 8;
    localparam logic [31:0] IMEM_HALT_WORD  = 32'hFFFF_FFFF;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        RECV,
        WRITE,
        DONE
    } imem_ld_state_t;

endpackage

// File: rtl/imem_loader_if.sv
// rtl/imem_loader_if.sv - byte stream and instruction memory port bundle for the loader
interface imem_loader_if;

    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic [31:0] fetch_pc;
    logic [31:0] mem_addr;
    logic        mem_we;
    logic [31:0] mem_wdata;

    modport master (
        input  rx_data, rx_valid, fetch_pc,
        output rx_ready, mem_addr, mem_we, mem_wdata
    );

    modport slave (
        output rx_data, rx_valid, fetch_pc,
        input  rx_ready, mem_addr, mem_we, mem_wdata
    );

endinterface

// File: rtl/imem_word_packer.sv
// rtl/imem_word_packer.sv - assembles four accepted bytes into a big-endian word
module imem_word_packer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        word_valid,
    output logic [31:0] word
);

    logic [1:0] idx;

    // Shifting left puts the first byte of a word in [31:24] once four bytes are in.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx  <= 2'd0;
            word <= 32'h0;
        end else if (clear) begin
            idx  <= 2'd0;
            word <= 32'h0;
        end else if (byte_valid) begin
            idx  <= idx + 2'd1;
            word <= {word[23:0], byte_data};
        end
    end

    assign word_valid = byte_valid && (idx == 2'd3);

endmodule

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - clears, loads and arbitrates the instruction memory port
module imem_loader
    import mips_pkg::*;
#(
    parameter int          ADDR_WIDTH = IMEM_ADDR_WIDTH,
    parameter logic [31:0] HALT_WORD  = IMEM_HALT_WORD
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                load_start,
    imem_loader_if.master       bus,
    output logic                cpu_hold,
    output logic                load_done,
    output logic                load_full,
    output logic [ADDR_WIDTH:0] words_loaded
);

    localparam logic [ADDR_WIDTH-1:0] PTR_MAX = {ADDR_WIDTH{1'b1}};
    localparam logic [ADDR_WIDTH:0]   WL_MAX  = {1'b1, {ADDR_WIDTH{1'b0}}};

    imem_ld_state_t        state;
    logic [ADDR_WIDTH-1:0] ptr;
    logic                  rx_ready_q;
    logic                  mem_we_q;
    logic                  word_valid;
    logic [31:0]           word;

    imem_word_packer u_packer (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (state == CLEAR),
        .byte_valid (bus.rx_valid && rx_ready_q),
        .byte_data  (bus.rx_data),
        .word_valid (word_valid),
        .word       (word)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            ptr          <= '0;
            rx_ready_q   <= 1'b0;
            mem_we_q     <= 1'b0;
            cpu_hold     <= 1'b1;
            load_done    <= 1'b0;
            load_full    <= 1'b0;
            words_loaded <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (load_start) begin
                        state    <= CLEAR;
                        ptr      <= '0;
                        mem_we_q <= 1'b1;
                    end
                end
                CLEAR: begin
                    // ptr wraps back to 0 after the last address, ready for loading.
                    ptr <= ptr + ADDR_WIDTH'(1);
                    if (ptr == PTR_MAX) begin
                        state      <= RECV;
                        mem_we_q   <= 1'b0;
                        rx_ready_q <= 1'b1;
                    end
                end
                RECV: begin
                    if (word_valid) begin
                        state      <= WRITE;
                        rx_ready_q <= 1'b0;
                        mem_we_q   <= 1'b1;
                    end
                end
                WRITE: begin
                    mem_we_q <= 1'b0;
                    if (words_loaded != WL_MAX) begin
                        words_loaded <= words_loaded + (ADDR_WIDTH+1)'(1);
                    end
                    // Halt is checked first so a halt word in the last slot is not reported as full.
                    if (word == HALT_WORD) begin
                        state     <= DONE;
                        load_full <= 1'b0;
                        load_done <= 1'b1;
                        cpu_hold  <= 1'b0;
                    end else if (ptr == PTR_MAX) begin
                        state     <= DONE;
                        load_full <= 1'b1;
                        load_done <= 1'b1;
                        cpu_hold  <= 1'b0;
                    end else begin
                        state      <= RECV;
                        ptr        <= ptr + ADDR_WIDTH'(1);
                        rx_ready_q <= 1'b1;
                    end
                end
                DONE: begin
                    if (load_start) begin
                        state        <= CLEAR;
                        ptr          <= '0;
                        mem_we_q     <= 1'b1;
                        cpu_hold     <= 1'b1;
                        load_done    <= 1'b0;
                        load_full    <= 1'b0;
                        words_loaded <= '0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.rx_ready  = rx_ready_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_wdata = (state == WRITE) ? word : 32'h0;
    assign bus.mem_addr  = (state == CLEAR || state == WRITE)
                         ? {{(32-ADDR_WIDTH-2){1'b0}}, ptr, 2'b00}
                         : bus.fetch_pc;

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - directed vector bench for imem_loader
module tb_imem_loader;

    logic       clk;
    logic       rst_n;
    logic       load_start;
    logic       cpu_hold;
    logic       load_done;
    logic       load_full;
    logic [8:0] words_loaded;

    imem_loader_if bus ();

    imem_loader dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .load_start   (load_start),
        .bus          (bus),
        .cpu_hold     (cpu_hold),
        .load_done    (load_done),
        .load_full    (load_full),
        .words_loaded (words_loaded)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    logic [31:0] wr_addr[$];
    logic [31:0] wr_data[$];
    int          wr_cyc[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.mem_we === 1'b1) begin
            wr_addr.push_back(bus.mem_addr);
            wr_data.push_back(bus.mem_wdata);
            wr_cyc.push_back(cyc);
        end
    end

    typedef struct {
        logic        vld;
        logic [7:0]  data;
        logic [31:0] pc;
        logic        e_rdy;
        logic        e_we;
        logic [31:0] e_addr;
        logic [31:0] e_wdata;
        logic        e_hold;
        logic        e_done;
        logic [8:0]  e_wl;
    } vec_t;

    vec_t vt[12];

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] word_of(input int i);
        logic [7:0] b;
        b = i[7:0];
        return {b, 8'h5A, ~b, 8'h3C};
    endfunction

    task automatic clear_log();
        wr_addr.delete();
        wr_data.delete();
        wr_cyc.delete();
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int n;
        repeat (gap) begin
            @(negedge clk);
            bus.rx_valid = 1'b0;
        end
        @(negedge clk);
        bus.rx_valid = 1'b1;
        bus.rx_data  = b;
        n = 0;
        while (bus.rx_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("rx_ready_wait", bus.rx_ready, 1'b1);
    endtask

    task automatic start_load();
        @(negedge clk);
        load_start = 1'b1;
        @(negedge clk);
        load_start = 1'b0;
    endtask

    task automatic wait_recv();
        int n;
        n = 0;
        while (bus.rx_ready !== 1'b1 && n < 400) begin
            @(negedge clk);
            n++;
        end
        check("wait_recv", bus.rx_ready, 1'b1);
    endtask

    task automatic stream_words(input int n, input bit halt_last);
        logic [31:0] wd;
        for (int w = 0; w < n; w++) begin
            wd = (halt_last && w == n - 1) ? 32'hFFFF_FFFF : word_of(w);
            for (int b = 0; b < 4; b++) send_byte(wd[31-8*b -: 8], 0);
        end
        @(negedge clk);
        bus.rx_valid = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int c0, hold_bad, bad, n4;

        vt[0]  = '{1'b1, 8'h20, 32'h100, 1'b1, 1'b0, 32'h100, 32'h0,        1'b1, 1'b0, 9'd0};
        vt[1]  = '{1'b1, 8'h08, 32'h104, 1'b1, 1'b0, 32'h104, 32'h0,        1'b1, 1'b0, 9'd0};
        vt[2]  = '{1'b1, 8'h00, 32'h108, 1'b1, 1'b0, 32'h108, 32'h0,        1'b1, 1'b0, 9'd0};
        vt[3]  = '{1'b1, 8'h05, 32'h10C, 1'b1, 1'b0, 32'h10C, 32'h0,        1'b1, 1'b0, 9'd0};
        vt[4]  = '{1'b0, 8'h00, 32'h200, 1'b0, 1'b1, 32'h000, 32'h20080005, 1'b1, 1'b0, 9'd0};
        vt[5]  = '{1'b1, 8'hFF, 32'h110, 1'b1, 1'b0, 32'h110, 32'h0,        1'b1, 1'b0, 9'd1};
        vt[6]  = '{1'b1, 8'hFF, 32'h114, 1'b1, 1'b0, 32'h114, 32'h0,        1'b1, 1'b0, 9'd1};
        vt[7]  = '{1'b1, 8'hFF, 32'h118, 1'b1, 1'b0, 32'h118, 32'h0,        1'b1, 1'b0, 9'd1};
        vt[8]  = '{1'b1, 8'hFF, 32'h11C, 1'b1, 1'b0, 32'h11C, 32'h0,        1'b1, 1'b0, 9'd1};
        vt[9]  = '{1'b0, 8'h00, 32'h300, 1'b0, 1'b1, 32'h004, 32'hFFFFFFFF, 1'b1, 1'b0, 9'd1};
        vt[10] = '{1'b0, 8'h00, 32'h008, 1'b0, 1'b0, 32'h008, 32'h0,        1'b0, 1'b1, 9'd2};
        vt[11] = '{1'b1, 8'h55, 32'h040, 1'b0, 1'b0, 32'h040, 32'h0,        1'b0, 1'b1, 9'd2};

        rst_n        = 1'b0;
        load_start   = 1'b0;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        bus.fetch_pc = 32'h1234_5678;

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_hold",   cpu_hold, 1'b1);
        check("rst_rdy",    bus.rx_ready, 1'b0);
        check("rst_we",     bus.mem_we, 1'b0);
        check("rst_wdata",  bus.mem_wdata, 32'h0);
        check("rst_done",   load_done, 1'b0);
        check("rst_full",   load_full, 1'b0);
        check("rst_wl",     words_loaded, 9'd0);
        check("rst_addr",   bus.mem_addr, 32'h1234_5678);
        rst_n = 1'b1;
        @(negedge clk);
        bus.fetch_pc = 32'h0000_0040;
        #1;
        check("idle_addr", bus.mem_addr, 32'h40);
        check("idle_hold", cpu_hold, 1'b1);

        // Clear sweep: 256 consecutive zero writes
        clear_log();
        @(negedge clk);
        load_start = 1'b1;
        c0 = cyc;
        hold_bad = 0;
        for (int i = 0; i < 256; i++) begin
            @(negedge clk);
            load_start = 1'b0;
            if (cpu_hold !== 1'b1) hold_bad++;
        end
        @(negedge clk);
        check("clr_hold", hold_bad, 0);
        check("clr_end_rdy", bus.rx_ready, 1'b1);
        check("clr_end_we", bus.mem_we, 1'b0);
        check("clr_count", wr_addr.size(), 256);
        bad = 0;
        for (int i = 0; i < wr_addr.size() && i < 256; i++) begin
            if (wr_addr[i] !== 32'(i * 4) || wr_data[i] !== 32'h0 || wr_cyc[i] != c0 + 1 + i) bad++;
        end
        check("clr_entries", bad, 0);

        // Table: 20 08 00 05 then halt word
        for (int i = 0; i < 12; i++) begin
            bus.rx_valid = vt[i].vld;
            bus.rx_data  = vt[i].data;
            bus.fetch_pc = vt[i].pc;
            #1;
            check($sformatf("v%0d_rdy", i),  bus.rx_ready, vt[i].e_rdy);
            check($sformatf("v%0d_we", i),   bus.mem_we, vt[i].e_we);
            check($sformatf("v%0d_addr", i), bus.mem_addr, vt[i].e_addr);
            if (vt[i].e_we) check($sformatf("v%0d_wdata", i), bus.mem_wdata, vt[i].e_wdata);
            check($sformatf("v%0d_hold", i), cpu_hold, vt[i].e_hold);
            check($sformatf("v%0d_done", i), load_done, vt[i].e_done);
            check($sformatf("v%0d_full", i), load_full, 1'b0);
            check($sformatf("v%0d_wl", i),   words_loaded, vt[i].e_wl);
            @(negedge clk);
        end
        bus.rx_valid = 1'b0;

        // load_start in DONE restarts with a clear
        load_start = 1'b1;
        @(negedge clk);
        load_start = 1'b0;
        check("redo_we", bus.mem_we, 1'b1);
        check("redo_addr", bus.mem_addr, 32'h0);
        check("redo_wl", words_loaded, 9'd0);
        check("redo_done", load_done, 1'b0);
        check("redo_hold", cpu_hold, 1'b1);
        wait_recv();

        // load_start during RECV is ignored
        load_start = 1'b1;
        @(negedge clk);
        load_start = 1'b0;
        check("recv_ign_rdy", bus.rx_ready, 1'b1);
        check("recv_ign_we", bus.mem_we, 1'b0);

        // Fill all 256 words without a halt
        clear_log();
        stream_words(256, 1'b0);
        check("full_count", wr_addr.size(), 256);
        bad = 0;
        for (int i = 0; i < wr_addr.size() && i < 256; i++) begin
            if (wr_addr[i] !== 32'(i * 4) || wr_data[i] !== word_of(i)) bad++;
        end
        check("full_entries", bad, 0);
        check("full_last_addr", wr_addr[wr_addr.size()-1], 32'h3FC);
        check("full_flag", load_full, 1'b1);
        check("full_done", load_done, 1'b1);
        check("full_hold", cpu_hold, 1'b0);
        check("full_wl", words_loaded, 9'd256);
        bus.rx_valid = 1'b1;
        bus.rx_data  = 8'hAA;
        repeat (3) @(negedge clk);
        check("full_rdy_after", bus.rx_ready, 1'b0);
        bus.rx_valid = 1'b0;

        // Halt word in the last slot wins over full
        start_load();
        wait_recv();
        clear_log();
        stream_words(256, 1'b1);
        check("prio_full", load_full, 1'b0);
        check("prio_done", load_done, 1'b1);
        check("prio_wl", words_loaded, 9'd256);
        check("prio_last_data", wr_data[wr_data.size()-1], 32'hFFFF_FFFF);
        check("prio_last_addr", wr_addr[wr_addr.size()-1], 32'h3FC);

        // Bursty bytes with gaps
        start_load();
        wait_recv();
        clear_log();
        send_byte(8'hDE, 0);
        send_byte(8'hAD, 3);
        send_byte(8'hBE, 1);
        send_byte(8'hEF, 2);
        n4 = cyc;
        @(negedge clk);
        bus.rx_valid = 1'b0;
        check("burst_we_lat", bus.mem_we, 1'b1);
        send_byte(8'hFF, 2);
        send_byte(8'hFF, 0);
        send_byte(8'hFF, 3);
        send_byte(8'hFF, 1);
        @(negedge clk);
        bus.rx_valid = 1'b0;
        @(negedge clk);
        check("burst_count", wr_data.size(), 2);
        check("burst_w0", wr_data[0], 32'hDEAD_BEEF);
        check("burst_a0", wr_addr[0], 32'h0);
        check("burst_c0", wr_cyc[0], n4 + 1);
        check("burst_w1", wr_data[1], 32'hFFFF_FFFF);
        check("burst_a1", wr_addr[1], 32'h4);
        check("burst_wl", words_loaded, 9'd2);
        check("burst_done", load_done, 1'b1);
        check("burst_full", load_full, 1'b0);

        // Async reset after two bytes discards the partial word
        start_load();
        wait_recv();
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        @(negedge clk);
        bus.rx_valid = 1'b0;
        bus.fetch_pc = 32'h0000_0ABC;
        rst_n = 1'b0;
        #1;
        check("arst_hold", cpu_hold, 1'b1);
        check("arst_rdy", bus.rx_ready, 1'b0);
        check("arst_we", bus.mem_we, 1'b0);
        check("arst_done", load_done, 1'b0);
        check("arst_wl", words_loaded, 9'd0);
        check("arst_addr", bus.mem_addr, 32'hABC);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        start_load();
        wait_recv();
        clear_log();
        send_byte(8'h33, 0);
        send_byte(8'h44, 0);
        send_byte(8'h55, 0);
        send_byte(8'h66, 0);
        @(negedge clk);
        bus.rx_valid = 1'b0;
        @(negedge clk);
        check("arst_count", wr_data.size(), 1);
        check("arst_word", wr_data[0], 32'h3344_5566);
        check("arst_waddr", wr_addr[0], 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
# imem_loader

Load controller and port arbiter for the instruction memory. It owns the write side and the shared address port of the 256-word instruction ROM/RAM. After reset or on command it clears the memory, then assembles big-endian 32-bit words from a UART byte stream and writes them sequentially from address 0. It holds the pipeline in stall until loading completes, then hands the address port back to the IF stage's PC.

## Interface
Parameters:
- `ADDR_WIDTH`, 8 — word-address width; memory depth is 2^ADDR_WIDTH words.
- `HALT_WORD`, 32'hFFFF_FFFF — end-of-program marker. It is written to memory, then loading ends.

Ports:
- `clk` input 1 — single clock.
- `rst_n` input 1 — one clock; reset is asynchronous and active-low.
- `load_start` input 1 — single-cycle request to begin a load session.
- `rx_data` input 8 — received byte.
- `rx_valid` input 1 — `rx_data` is valid this cycle.
- `rx_ready` output 1 — loader accepts a byte this cycle.
- `fetch_pc` input 32 — byte address from IF.
- `mem_addr` output 32 — byte address to the instruction memory.
- `mem_we` output 1 — write enable to the instruction memory.
- `mem_wdata` output 32 — write data to the instruction memory.
- `cpu_hold` output 1 — stalls PC and pipeline.
- `load_done` output 1 — program present; CPU may run.
- `load_full` output 1 — session ended by filling memory, not by `HALT_WORD`.
- `words_loaded` output ADDR_WIDTH+1 — count of words written in the last session.

## Operation
State machine states:
- IDLE: `cpu_hold`=1. `load_start` → CLEAR.
- CLEAR: `mem_we`=1, `mem_wdata`=0, `mem_addr`={ptr,2'b00}, ptr increments every cycle. Occupies 2^ADDR_WIDTH cycles. After writing the last address, ptr wraps to 0 → RECV.
- RECV: `rx_ready`=1. A byte is accepted when `rx_valid` and `rx_ready` are both high.
  - Byte order: first byte → bits [31:24], last byte → [7:0].
  - The fourth accepted byte → WRITE.
- WRITE: one cycle. `mem_we`=1, `mem_wdata`=assembled word, `mem_addr`={ptr,2'b00}, `words_loaded`++.
  - Word == `HALT_WORD` → DONE, `load_full`=0.
  - ptr == 2^ADDR_WIDTH−1 → DONE, `load_full`=1.
  - Otherwise ptr++ → RECV.
- DONE: `cpu_hold`=0, `load_done`=1, `mem_addr`=`fetch_pc`. `load_start` → CLEAR and clears `load_done`, `load_full`, `words_loaded`.

Arbitration and boundary rules:
- `mem_addr` selects `{ptr,2'b00}` in CLEAR and WRITE. In all other states it selects `fetch_pc`.
- `mem_we` is high only in CLEAR and WRITE.
- `load_start` is ignored in CLEAR, RECV and WRITE.
- `rx_ready`=0 outside RECV. Bytes presented then are not consumed; upstream holds or drops them.
- `HALT_WORD` and full on the same word: halt takes priority, so `load_full`=0.
- Reset mid-session: return to IDLE, discard any partial word. Memory contents already written are not restored.

Reset values:
- State IDLE, ptr 0, byte index 0.
- `cpu_hold`=1, `rx_ready`=0, `mem_we`=0, `mem_wdata`=0.
- `load_done`=0, `load_full`=0, `words_loaded`=0.
- `mem_addr`=`fetch_pc`.

## Timing
- All state, ptr, byte index, word register and flags are registered on `clk` rising edge. Outputs decode combinationally from registered state; `mem_addr` also depends combinationally on `fetch_pc`.
- Latency:
  - `load_start` → first CLEAR write: 1 cycle.
  - CLEAR duration: exactly 2^ADDR_WIDTH cycles.
  - Fourth byte accepted in cycle N → `mem_we` in cycle N+1.
  - Final WRITE in cycle M → `cpu_hold` low and `load_done` high in cycle M+1.
- Throughput: at most one byte per cycle in RECV. A word therefore takes at least 5 cycles (4 RECV + 1 WRITE).
- `words_loaded` updates in the cycle after WRITE and saturates at 2^ADDR_WIDTH.

## Structure
- Shared package `mips_pkg` holds:
  - state enum `imem_ld_state_t` {IDLE, CLEAR, RECV, WRITE, DONE};
  - constants `IMEM_ADDR_WIDTH`=8 and `IMEM_HALT_WORD`.
- One sub-module: `imem_word_packer`. It contains the byte index counter and 32-bit shift register, and outputs `word_valid` and `word`. It is cleared on entering RECV from CLEAR and on reset.
- The FSM, ptr and arbitration mux stay in `imem_loader`.

## Test plan
- Reset then `load_start`:
  - exactly 256 consecutive `mem_we` cycles with `mem_wdata`=0 and addresses 0x000…0x3FC;
  - `cpu_hold` stays 1 throughout.
- Send bytes 20 08 00 05, FF FF FF FF:
  - writes 0x20080005 @0x000 and 0xFFFFFFFF @0x004;
  - `words_loaded`=2, `load_done`=1, `load_full`=0;
  - `mem_addr` then tracks `fetch_pc`=0x8.
- Stream 256 non-halt words:
  - last write @0x3FC, `load_full`=1, `load_done`=1;
  - `rx_ready`=0 afterwards.
- Bursty `rx_valid` (gaps of 0–3 cycles) with one halt word:
  - assembled word unchanged;
  - `mem_we` exactly 1 cycle after the 4th accepted byte.
- Async `rst_n` low after 2 bytes of a word:
  - outputs go to reset values immediately;
  - new `load_start` plus 4 bytes writes the fresh word @0x000 with no stale bytes.
- `load_start` pulsed during RECV: ignored, no CLEAR restart. `load_start` in DONE: re-clears and sets `words_loaded`=0.
